// File: rtl/commit_trace_buffer.sv
// Retire-trace monitor: packs committed instructions into records, queues them in a circular
// buffer drained over valid/ready, and tracks retire/cycle counts, halt and a cycle watchdog.
module commit_trace_buffer #(
    parameter int unsigned AW         = 16,
    parameter int unsigned DW         = 16,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned CW         = 32,
    parameter int unsigned MAX_CYCLES = 100000,
    parameter int unsigned OVERWRITE  = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     commit_valid,
    input  logic [AW-1:0]            commit_pc,
    input  logic                     commit_regwrite,
    input  logic [3:0]               commit_reg,
    input  logic [DW-1:0]            commit_wdata,
    input  logic                     commit_memread,
    input  logic                     commit_memwrite,
    input  logic [AW-1:0]            commit_addr,
    input  logic [DW-1:0]            commit_mdata,
    input  logic                     commit_halt,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [2+4+2*AW+DW-1:0]   rd_data,
    output logic [CW-1:0]            inst_count,
    output logic [CW-1:0]            cycle_count,
    output logic [CW-1:0]            drop_count,
    output logic                     overflow,
    output logic                     halted,
    output logic                     timeout,
    output logic                     done
);

    localparam int unsigned RW = 2 + 4 + 2 * AW + DW;
    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned PW = IW + 1;

    typedef enum logic [1:0] {StRun, StHalted, StTimeout} state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   inst_q, inst_d, cycle_q, cycle_d, drop_q, drop_d;
    logic            overflow_q, overflow_d;
    logic [RW-1:0]   mem_q [DEPTH];

    logic            empty, full, push, pop, mem_we, drop, wd_hit;
    logic [1:0]      rec_kind;
    logic [3:0]      rec_reg;
    logic [DW-1:0]   rec_val;
    logic [AW-1:0]   rec_addr;
    logic [RW-1:0]   record;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + CW'(1);
    endfunction

    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]) && (wr_ptr_q[IW] != rd_ptr_q[IW]);
    assign push   = commit_valid && (state_q == StRun);
    assign pop    = !empty && rd_ready;
    assign wd_hit = (MAX_CYCLES != 0) && (cycle_q == CW'(MAX_CYCLES - 1));

    always_comb begin
        rec_kind = 2'd0;
        rec_reg  = '0;
        rec_val  = '0;
        rec_addr = '0;
        if (commit_halt) begin
            rec_kind = 2'd3;
        end else if (commit_regwrite) begin
            rec_kind = 2'd1;
            rec_reg  = commit_reg;
            rec_val  = commit_wdata;
            rec_addr = commit_memread ? commit_addr : '0;
        end else if (commit_memwrite) begin
            rec_kind = 2'd2;
            rec_val  = commit_mdata;
            rec_addr = commit_addr;
        end
        record = {rec_kind, rec_reg, commit_pc, rec_val, rec_addr};
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_we   = 1'b0;
        drop     = 1'b0;
        if (push) begin
            // A same-cycle pop frees the slot, so a full buffer still accepts the record.
            if (!full || pop) begin
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + PW'(1);
            end else begin
                drop = 1'b1;
                if (OVERWRITE != 0) begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + PW'(1);
                    rd_ptr_d = rd_ptr_q + PW'(1);
                end
            end
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_comb begin
        state_d    = state_q;
        inst_d     = push ? sat_inc(inst_q) : inst_q;
        cycle_d    = (state_q == StRun) ? sat_inc(cycle_q) : cycle_q;
        drop_d     = drop ? sat_inc(drop_q) : drop_q;
        overflow_d = overflow_q | drop;
        if (state_q == StRun) begin
            if (push && commit_halt) begin
                state_d = StHalted;
            end else if (wd_hit) begin
                state_d = StTimeout;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StRun;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            inst_q     <= '0;
            cycle_q    <= '0;
            drop_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            inst_q     <= inst_d;
            cycle_q    <= cycle_d;
            drop_q     <= drop_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q[IW-1:0]] <= record;
        end
    end

    assign rd_valid    = !empty;
    assign rd_data     = mem_q[rd_ptr_q[IW-1:0]];
    assign inst_count  = inst_q;
    assign cycle_count = cycle_q;
    assign drop_count  = drop_q;
    assign overflow    = overflow_q;
    assign halted      = (state_q == StHalted);
    assign timeout     = (state_q == StTimeout);
    assign done        = (state_q != StRun) && empty;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed bench for commit_trace_buffer: drop/overwrite/watchdog variants share one stimulus bus.
module tb_commit_trace_buffer;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int RW = 2 + 4 + 2 * AW + DW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          commit_valid, commit_regwrite, commit_memread, commit_memwrite, commit_halt;
    logic [AW-1:0] commit_pc, commit_addr;
    logic [3:0]    commit_reg;
    logic [DW-1:0] commit_wdata, commit_mdata;
    logic          rd_ready;

    logic          a_valid, a_ovf, a_halt, a_to, a_done;
    logic [RW-1:0] a_data;
    logic [31:0]   a_inst, a_cyc, a_drop;
    logic          b_valid, b_ovf, b_halt, b_to, b_done;
    logic [RW-1:0] b_data;
    logic [3:0]    b_inst, b_cyc, b_drop;
    logic          w_valid, w_ovf, w_halt, w_to, w_done;
    logic [RW-1:0] w_data;
    logic [31:0]   w_inst, w_cyc, w_drop;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    commit_trace_buffer #(.AW(AW), .DW(DW), .DEPTH(4), .CW(32), .MAX_CYCLES(0), .OVERWRITE(0))
    dut_a (
        .clk(clk), .rst_n(rst_n), .commit_valid(commit_valid), .commit_pc(commit_pc),
        .commit_regwrite(commit_regwrite), .commit_reg(commit_reg), .commit_wdata(commit_wdata),
        .commit_memread(commit_memread), .commit_memwrite(commit_memwrite),
        .commit_addr(commit_addr), .commit_mdata(commit_mdata), .commit_halt(commit_halt),
        .rd_ready(rd_ready), .rd_valid(a_valid), .rd_data(a_data), .inst_count(a_inst),
        .cycle_count(a_cyc), .drop_count(a_drop), .overflow(a_ovf), .halted(a_halt),
        .timeout(a_to), .done(a_done)
    );

    commit_trace_buffer #(.AW(AW), .DW(DW), .DEPTH(4), .CW(4), .MAX_CYCLES(0), .OVERWRITE(1))
    dut_b (
        .clk(clk), .rst_n(rst_n), .commit_valid(commit_valid), .commit_pc(commit_pc),
        .commit_regwrite(commit_regwrite), .commit_reg(commit_reg), .commit_wdata(commit_wdata),
        .commit_memread(commit_memread), .commit_memwrite(commit_memwrite),
        .commit_addr(commit_addr), .commit_mdata(commit_mdata), .commit_halt(commit_halt),
        .rd_ready(rd_ready), .rd_valid(b_valid), .rd_data(b_data), .inst_count(b_inst),
        .cycle_count(b_cyc), .drop_count(b_drop), .overflow(b_ovf), .halted(b_halt),
        .timeout(b_to), .done(b_done)
    );

    commit_trace_buffer #(.AW(AW), .DW(DW), .DEPTH(4), .CW(32), .MAX_CYCLES(10), .OVERWRITE(0))
    dut_w (
        .clk(clk), .rst_n(rst_n), .commit_valid(commit_valid), .commit_pc(commit_pc),
        .commit_regwrite(commit_regwrite), .commit_reg(commit_reg), .commit_wdata(commit_wdata),
        .commit_memread(commit_memread), .commit_memwrite(commit_memwrite),
        .commit_addr(commit_addr), .commit_mdata(commit_mdata), .commit_halt(commit_halt),
        .rd_ready(rd_ready), .rd_valid(w_valid), .rd_data(w_data), .inst_count(w_inst),
        .cycle_count(w_cyc), .drop_count(w_drop), .overflow(w_ovf), .halted(w_halt),
        .timeout(w_to), .done(w_done)
    );

    typedef struct {
        logic          valid;
        logic [15:0]   pc;
        logic          regwrite;
        logic [3:0]    rg;
        logic [15:0]   wdata;
        logic          memread;
        logic          memwrite;
        logic [15:0]   addr;
        logic [15:0]   mdata;
        logic          ready;
        logic          exp_valid;
        logic          chk_data;
        logic [RW-1:0] exp_data;
        logic [31:0]   exp_inst;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        commit_valid    = 1'b0;
        commit_pc       = '0;
        commit_regwrite = 1'b0;
        commit_reg      = '0;
        commit_wdata    = '0;
        commit_memread  = 1'b0;
        commit_memwrite = 1'b0;
        commit_addr     = '0;
        commit_mdata    = '0;
        commit_halt     = 1'b0;
    endtask

    task automatic reg_commit(input logic [15:0] pc, input logic [3:0] rg,
                              input logic [15:0] wd);
        idle();
        commit_valid    = 1'b1;
        commit_pc       = pc;
        commit_regwrite = 1'b1;
        commit_reg      = rg;
        commit_wdata    = wd;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        rd_ready = 1'b0;
        idle();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL global time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        vecs[0] = '{1'b1, 16'h0004, 1'b1, 4'd3, 16'hBEEF, 1'b0, 1'b0, 16'h0000, 16'h0000,
                    1'b0, 1'b1, 1'b1, {2'd1, 4'd3, 16'h0004, 16'hBEEF, 16'h0000}, 32'd1};
        vecs[1] = '{1'b0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000,
                    1'b1, 1'b0, 1'b0, '0, 32'd1};
        vecs[2] = '{1'b1, 16'h0008, 1'b1, 4'd5, 16'h1234, 1'b1, 1'b0, 16'h0100, 16'h0000,
                    1'b0, 1'b1, 1'b1, {2'd1, 4'd5, 16'h0008, 16'h1234, 16'h0100}, 32'd2};
        vecs[3] = '{1'b1, 16'h000C, 1'b0, 4'd7, 16'h1111, 1'b0, 1'b1, 16'h0200, 16'hCAFE,
                    1'b1, 1'b1, 1'b1, {2'd2, 4'd0, 16'h000C, 16'hCAFE, 16'h0200}, 32'd3};
        vecs[4] = '{1'b1, 16'h0010, 1'b0, 4'd9, 16'h5555, 1'b0, 1'b0, 16'h0300, 16'h7777,
                    1'b1, 1'b1, 1'b1, {2'd0, 4'd0, 16'h0010, 16'h0000, 16'h0000}, 32'd4};
        vecs[5] = '{1'b1, 16'h0014, 1'b1, 4'd2, 16'h00AA, 1'b0, 1'b1, 16'h0400, 16'hBBBB,
                    1'b1, 1'b1, 1'b1, {2'd1, 4'd2, 16'h0014, 16'h00AA, 16'h0000}, 32'd5};
        vecs[6] = '{1'b0, 16'h0018, 1'b1, 4'd4, 16'h9999, 1'b0, 1'b0, 16'h0000, 16'h0000,
                    1'b1, 1'b0, 1'b0, '0, 32'd5};
        vecs[7] = '{1'b0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000,
                    1'b1, 1'b0, 1'b0, '0, 32'd5};

        // Reset state and first RUN cycle
        do_reset();
        check("reset rd_valid", a_valid, 0);
        check("reset inst", a_inst, 0);
        check("reset cycle", a_cyc, 0);
        check("reset drop", a_drop, 0);
        check("reset flags", {a_ovf, a_halt, a_to}, 0);
        check("reset done", a_done, 0);
        tick();
        check("cycle after release", a_cyc, 1);

        // Record formats and basic push/pop
        for (int i = 0; i < 8; i++) begin
            idle();
            commit_valid    = vecs[i].valid;
            commit_pc       = vecs[i].pc;
            commit_regwrite = vecs[i].regwrite;
            commit_reg      = vecs[i].rg;
            commit_wdata    = vecs[i].wdata;
            commit_memread  = vecs[i].memread;
            commit_memwrite = vecs[i].memwrite;
            commit_addr     = vecs[i].addr;
            commit_mdata    = vecs[i].mdata;
            rd_ready        = vecs[i].ready;
            tick();
            check($sformatf("vec%0d rd_valid", i), a_valid, vecs[i].exp_valid);
            check($sformatf("vec%0d inst", i), a_inst, vecs[i].exp_inst);
            if (vecs[i].chk_data) check($sformatf("vec%0d rd_data", i), a_data, vecs[i].exp_data);
        end
        idle();
        rd_ready = 1'b0;

        // Fill past capacity: drop vs overwrite
        do_reset();
        for (int i = 0; i < 6; i++) begin
            reg_commit(16'h0100 + 16'(i), 4'(i), 16'(i));
            tick();
        end
        idle();
        check("fill a drop", a_drop, 2);
        check("fill a overflow", a_ovf, 1);
        check("fill a inst", a_inst, 6);
        check("fill b drop", b_drop, 2);
        check("fill b overflow", b_ovf, 1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("fill a head%0d", i), a_data[47:32], 16'h0100 + 16'(i));
            check($sformatf("fill b head%0d", i), b_data[47:32], 16'h0102 + 16'(i));
            rd_ready = 1'b1;
            tick();
            rd_ready = 1'b0;
        end
        check("fill a drained", a_valid, 0);
        check("fill b drained", b_valid, 0);

        // Full buffer with simultaneous push and pop across pointer wrap
        do_reset();
        for (int i = 0; i < 4; i++) begin
            reg_commit(16'h0200 + 16'(i), 4'd1, 16'h0);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            reg_commit(16'h0204 + 16'(i), 4'd1, 16'h0);
            rd_ready = 1'b1;
            tick();
        end
        idle();
        rd_ready = 1'b0;
        check("pushpop a drop", a_drop, 0);
        check("pushpop a overflow", a_ovf, 0);
        check("pushpop b drop", b_drop, 0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("pushpop head%0d", i), a_data[47:32], 16'h0204 + 16'(i));
            rd_ready = 1'b1;
            tick();
            rd_ready = 1'b0;
        end
        check("pushpop drained", a_valid, 0);

        // Halt, post-halt commits ignored, done after drain
        do_reset();
        reg_commit(16'h001C, 4'd1, 16'h0011);
        tick();
        idle();
        commit_valid    = 1'b1;
        commit_halt     = 1'b1;
        commit_pc       = 16'h0020;
        commit_regwrite = 1'b1;
        commit_reg      = 4'd6;
        commit_wdata    = 16'h7777;
        commit_memwrite = 1'b1;
        commit_addr     = 16'h0055;
        commit_mdata    = 16'h0066;
        tick();
        for (int i = 0; i < 3; i++) begin
            reg_commit(16'h0024 + 16'(4 * i), 4'd2, 16'h0);
            tick();
        end
        idle();
        check("halt halted", a_halt, 1);
        check("halt timeout", a_to, 0);
        check("halt inst frozen", a_inst, 2);
        check("halt cycle frozen", a_cyc, 2);
        check("halt done early", a_done, 0);
        check("halt head pc", a_data[47:32], 16'h001C);
        rd_ready = 1'b1;
        tick();
        check("halt record", a_data, {2'd3, 4'd0, 16'h0020, 16'h0000, 16'h0000});
        check("halt done pending", a_done, 0);
        tick();
        rd_ready = 1'b0;
        check("halt drained", a_valid, 0);
        check("halt done", a_done, 1);

        // Watchdog
        do_reset();
        repeat (9) tick();
        check("wd cycle 9", w_cyc, 9);
        check("wd not yet", w_to, 0);
        tick();
        check("wd fired", w_to, 1);
        check("wd cycle 10", w_cyc, 10);
        check("wd not halted", w_halt, 0);
        repeat (3) tick();
        check("wd cycle frozen", w_cyc, 10);
        check("wd done", w_done, 1);
        check("wd disabled", a_to, 0);
        check("wd disabled cycle", a_cyc, 13);

        // Halt and watchdog in the same cycle
        do_reset();
        repeat (9) tick();
        idle();
        commit_valid = 1'b1;
        commit_halt  = 1'b1;
        commit_pc    = 16'h0040;
        tick();
        idle();
        check("tie halted", w_halt, 1);
        check("tie timeout", w_to, 0);
        check("tie cycle", w_cyc, 10);
        check("tie inst", w_inst, 1);
        check("tie record kind", w_data[RW-1:RW-2], 3);
        check("tie done", w_done, 0);

        // Counter saturation on the narrow-counter instance
        do_reset();
        for (int i = 0; i < 20; i++) begin
            reg_commit(16'h0300 + 16'(i), 4'd1, 16'h0);
            tick();
        end
        idle();
        check("sat b inst", b_inst, 15);
        check("sat b drop", b_drop, 15);
        check("sat b cycle", b_cyc, 15);
        check("sat b head", b_data[47:32], 16'h0310);
        check("sat a inst", a_inst, 20);
        check("sat a drop", a_drop, 16);
        check("sat a head", a_data[47:32], 16'h0300);

        // Reset mid-drain discards queued records
        rd_ready = 1'b1;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n    = 1'b1;
        rd_ready = 1'b0;
        check("midreset empty", a_valid, 0);
        check("midreset overflow", a_ovf, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
